// File: rtl/gsim_param_if.sv
// gsim_param_if: job-level stream bundle for the gsim_param Gauss-Seidel solver.
//
// Handshake semantics (there is no back-pressure in either direction):
//   in_en/b_in   - the source presents one b element per cycle with in_en=1.
//                  A job is N back-to-back in_en cycles. iter_max and tol are
//                  only looked at on the first in_en cycle of a job. in_en is
//                  ignored while a job is solving or streaming out.
//   out_valid    - the solver presents x[0..N-1] on N consecutive cycles. The
//                  sink must accept every element on the cycle it is offered.
//                  sweeps_out is meaningful only while out_valid=1, and x_out
//                  and sweeps_out read 0 otherwise.
//   busy         - high while a job occupies the solver.
//   err          - one-cycle pulse when a load stops before N elements.
//
// Modports:
//   master - the environment (drives job inputs, observes results)
//   slave  - the solver
interface gsim_param_if #(
  parameter int ITER_W = 8
);
  logic                     in_en;
  logic signed [15:0]       b_in;
  logic        [ITER_W-1:0] iter_max;
  logic        [31:0]       tol;
  logic                     out_valid;
  logic signed [31:0]       x_out;
  logic                     busy;
  logic        [ITER_W-1:0] sweeps_out;
  logic                     err;

  modport master (
    output in_en, b_in, iter_max, tol,
    input  out_valid, x_out, busy, sweeps_out, err
  );

  modport slave (
    input  in_en, b_in, iter_max, tol,
    output out_valid, x_out, busy, sweeps_out, err
  );
endinterface

// File: rtl/gsim_param.sv
// gsim_param: Gauss-Seidel solver for the banded system A*x = b with
// A = pentadiagonal-plus band {-1, 6, -13, 20, -13, 6, -1} (diagonals -3..+3).
// One job at a time: load N b elements, sweep until the sweep limit or the
// convergence tolerance is met, then stream x out in index order.
//
// Ports:
//   clk        - clock, rising edge
//   rst_in     - asynchronous reset, active high
//   bus        - gsim_param_if.slave: in_en, b_in, iter_max, tol (in);
//                out_valid, x_out, busy, sweeps_out, err (out)
//   state_dbg  - current FSM state (IDLE=0, LOAD=1, SOLVE=2, OUT=3)
//
// Parameters:
//   N      - number of unknowns, 4..64
//   ITER_W - width of the sweep limit / sweep count
module gsim_param #(
  parameter int N      = 16,
  parameter int ITER_W = 8
) (
  input  logic               clk,
  input  logic               rst_in,
  gsim_param_if.slave        bus,
  output logic [1:0]         state_dbg
);

  localparam int IW = $clog2(N);
  // Wide enough to hold idx+3 without wrapping, for the boundary tests.
  localparam int CW = IW + 2;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic signed [47:0] QMAX = 48'sd2147483647;
  localparam logic signed [47:0] QMIN = -48'sd2147483648;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SOLVE = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t state, state_nx;

  // One index serves as load pointer k, solve pointer i and output pointer j.
  logic        [IW-1:0]     idx;
  logic signed [15:0]       b_mem [N];
  logic signed [31:0]       x_mem [N];
  logic        [ITER_W-1:0] lim_r;
  logic        [ITER_W-1:0] cnt_r;
  logic        [31:0]       tol_r;
  logic        [32:0]       dmax_r;
  logic                     err_r;

  logic                     last_idx;
  assign last_idx  = (idx == LAST);
  assign state_dbg = state;

  function automatic logic signed [47:0] sx(input logic signed [31:0] v);
    sx = {{16{v[31]}}, v};
  endfunction

  // ---------------------------------------------------------------------------
  // Solve datapath: one Gauss-Seidel row update per cycle.
  // x_mem already holds updated values below idx and previous-sweep values
  // above idx, so reading it directly gives true Gauss-Seidel ordering.
  // ---------------------------------------------------------------------------
  logic        [CW-1:0] ie;
  logic signed [47:0]   xm1, xm2, xm3, xp1, xp2, xp3;
  logic signed [47:0]   s_acc, q_t, r_t, q_f;
  logic signed [31:0]   x_new, x_old;
  logic        [32:0]   diff, d_abs, sweep_max;
  logic        [ITER_W-1:0] cnt_inc;
  logic                 sweep_done;

  always_comb begin
    ie    = CW'(idx);
    xm1   = '0;
    xm2   = '0;
    xm3   = '0;
    xp1   = '0;
    xp2   = '0;
    xp3   = '0;
    if (ie >= CW'(1))          xm1 = sx(x_mem[idx - IW'(1)]);
    if (ie >= CW'(2))          xm2 = sx(x_mem[idx - IW'(2)]);
    if (ie >= CW'(3))          xm3 = sx(x_mem[idx - IW'(3)]);
    if (ie + CW'(1) < CW'(N))  xp1 = sx(x_mem[idx + IW'(1)]);
    if (ie + CW'(2) < CW'(N))  xp2 = sx(x_mem[idx + IW'(2)]);
    if (ie + CW'(3) < CW'(N))  xp3 = sx(x_mem[idx + IW'(3)]);

    s_acc = $signed({{16{b_mem[idx][15]}}, b_mem[idx], 16'h0000})
          + 48'sd13 * (xm1 + xp1)
          - 48'sd6  * (xm2 + xp2)
          + (xm3 + xp3);

    // Division truncates toward zero; pull negative inexact quotients down
    // by one so the result is a true floor.
    q_t = s_acc / 48'sd20;
    r_t = s_acc % 48'sd20;
    q_f = ((r_t != 48'sd0) && s_acc[47]) ? (q_t - 48'sd1) : q_t;

    if (q_f > QMAX)      x_new = 32'sh7FFFFFFF;
    else if (q_f < QMIN) x_new = 32'sh80000000;
    else                 x_new = q_f[31:0];

    // Both operands fit in 32 signed bits, so a 33-bit difference never
    // overflows and its magnitude fits in 33 unsigned bits.
    x_old = x_mem[idx];
    diff  = {x_new[31], x_new} - {x_old[31], x_old};
    d_abs = diff[32] ? (33'd0 - diff) : diff;

    sweep_max  = ((idx == '0) || (d_abs > dmax_r)) ? d_abs : dmax_r;
    cnt_inc    = (&cnt_r) ? cnt_r : (cnt_r + ITER_W'(1));
    sweep_done = (cnt_inc >= lim_r) || (sweep_max <= {1'b0, tol_r});
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= state_nx;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx       = state;
    bus.out_valid  = 1'b0;
    bus.x_out      = '0;
    bus.busy       = 1'b0;
    bus.sweeps_out = '0;
    bus.err        = err_r;

    case (state)
      S_IDLE: begin
        if (bus.in_en) state_nx = S_LOAD;
      end
      S_LOAD: begin
        bus.busy = 1'b1;
        if (!bus.in_en)    state_nx = S_IDLE;
        else if (last_idx) state_nx = S_SOLVE;
      end
      S_SOLVE: begin
        bus.busy = 1'b1;
        if (last_idx && sweep_done) state_nx = S_OUT;
      end
      S_OUT: begin
        bus.busy       = 1'b1;
        bus.out_valid  = 1'b1;
        bus.x_out      = x_mem[idx];
        bus.sweeps_out = cnt_r;
        if (last_idx) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Job storage, pointers and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      idx    <= '0;
      lim_r  <= '0;
      cnt_r  <= '0;
      tol_r  <= '0;
      dmax_r <= '0;
      err_r  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        x_mem[i] <= '0;
        b_mem[i] <= '0;
      end
    end else begin
      err_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.in_en) begin
            b_mem[0] <= bus.b_in;
            lim_r    <= (bus.iter_max == '0) ? ITER_W'(1) : bus.iter_max;
            tol_r    <= bus.tol;
            cnt_r    <= '0;
            dmax_r   <= '0;
            idx      <= IW'(1);
            for (int i = 0; i < N; i++) x_mem[i] <= '0;
          end
        end
        S_LOAD: begin
          if (!bus.in_en) begin
            err_r <= 1'b1;
            idx   <= '0;
          end else begin
            b_mem[idx] <= bus.b_in;
            idx        <= last_idx ? '0 : (idx + IW'(1));
          end
        end
        S_SOLVE: begin
          x_mem[idx] <= x_new;
          dmax_r     <= sweep_max;
          if (last_idx) begin
            cnt_r <= cnt_inc;
            idx   <= '0;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        S_OUT: begin
          idx <= last_idx ? '0 : (idx + IW'(1));
        end
        default: idx <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_gsim_param.sv
// tb_gsim_param: randomized scoreboard bench for gsim_param, using one
// N=16 instance and one N=8 instance sharing clock and reset.
module tb_gsim_param;

  localparam int W = 40; // {sweeps_out[7:0], x_out[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gsim_param_if #(.ITER_W(8)) if16();
  gsim_param_if #(.ITER_W(8)) if8();
  logic [1:0] st16, st8;

  gsim_param #(.N(16), .ITER_W(8)) dut16 (
    .clk(clk), .rst_in(rst), .bus(if16), .state_dbg(st16)
  );
  gsim_param #(.N(8), .ITER_W(8)) dut8 (
    .clk(clk), .rst_in(rst), .bus(if8), .state_dbg(st8)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q16[$];
  logic [W-1:0] exp_q8[$];
  logic [W-1:0] e16, e8;
  int err_seen16 = 0;
  int err_seen8  = 0;
  logic signed [15:0] bvec[64];
  longint xm[64];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint nbr(input int n, input int j);
    if (j < 0 || j >= n) return 0;
    return xm[j];
  endfunction

  task automatic model(input int n, input int im, input longint tl, output int sw);
    longint s, q, d, maxd;
    int lim;
    for (int j = 0; j < 64; j++) xm[j] = 0;
    lim = (im == 0) ? 1 : im;
    sw  = 0;
    while (1) begin
      maxd = 0;
      for (int i = 0; i < n; i++) begin
        s = longint'(bvec[i]) * 65536
          + 13 * (nbr(n, i-1) + nbr(n, i+1))
          - 6  * (nbr(n, i-2) + nbr(n, i+2))
          + (nbr(n, i-3) + nbr(n, i+3));
        q = s / 20;
        if ((s % 20 != 0) && (s < 0)) q = q - 1;
        if (q > 64'sd2147483647) q = 64'sd2147483647;
        else if (q < -64'sd2147483648) q = -64'sd2147483648;
        d = q - xm[i];
        if (d < 0) d = -d;
        if (d > maxd) maxd = d;
        xm[i] = q;
      end
      sw++;
      if (sw >= lim || maxd <= tl) break;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int sel, input logic en, input logic [15:0] b,
                       input logic [7:0] im, input logic [31:0] tl);
    if (sel == 0) begin
      if16.in_en = en; if16.b_in = b; if16.iter_max = im; if16.tol = tl;
    end else begin
      if8.in_en = en; if8.b_in = b; if8.iter_max = im; if8.tol = tl;
    end
  endtask

  function automatic logic ov(input int sel);
    return (sel == 0) ? if16.out_valid : if8.out_valid;
  endfunction

  function automatic logic bsy(input int sel);
    return (sel == 0) ? if16.busy : if8.busy;
  endfunction

  function automatic void rand_b();
    for (int k = 0; k < 64; k++) bvec[k] = 16'($urandom);
  endfunction

  // Drives cnt elements; iter_max/tol are only meaningful on the first,
  // later cycles carry junk to confirm they are not resampled.
  task automatic load_job(input int sel, input int cnt, input int im, input logic [31:0] tl);
    for (int k = 0; k < cnt; k++) begin
      @(posedge clk); #1;
      if (k == 0) drive(sel, 1'b1, bvec[0], 8'(im), tl);
      else        drive(sel, 1'b1, bvec[k], 8'($urandom), $urandom);
      if (k == 0) begin
        @(negedge clk);
        check($sformatf("busy_low_first_load_sel%0d", sel), 64'(bsy(sel)), 0);
      end
    end
    @(posedge clk); #1;
    drive(sel, 1'b0, 16'h0, 8'h0, 32'h0);
  endtask

  task automatic run_job(input int sel, input int im, input logic [31:0] tl, input bit noise);
    int n, sw, lat, outs;
    n = (sel == 0) ? 16 : 8;
    model(n, im, longint'(tl), sw);
    for (int j = 0; j < n; j++) begin
      if (sel == 0) exp_q16.push_back({8'(sw), 32'(xm[j])});
      else          exp_q8.push_back({8'(sw), 32'(xm[j])});
    end
    load_job(sel, n, im, tl);
    lat = 1;
    @(negedge clk);
    while (!ov(sel) && lat < 3000) begin
      @(posedge clk); #1;
      lat++;
      if (noise) drive(sel, 1'($urandom), 16'($urandom), 8'($urandom), $urandom);
      @(negedge clk);
    end
    check($sformatf("first_out_latency_n%0d", n), 64'(lat), 64'(sw * n + 1));
    outs = ov(sel) ? 1 : 0;
    while (outs < n && lat < 6000) begin
      @(posedge clk); #1;
      lat++;
      if (noise) drive(sel, 1'($urandom), 16'($urandom), 8'($urandom), $urandom);
      @(negedge clk);
      if (ov(sel)) outs++;
    end
    check($sformatf("out_count_n%0d", n), 64'(outs), 64'(n));
    drive(sel, 1'b0, 16'h0, 8'h0, 32'h0);
  endtask

  task automatic short_load();
    int e0;
    e0 = err_seen16;
    rand_b();
    load_job(0, 5, 4, 32'h0);
    @(negedge clk);
    check("short_busy_while_loading", 64'(if16.busy), 1);
    check("short_err_before", 64'(if16.err), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("short_err_pulse", 64'(if16.err), 1);
    check("short_busy_fall", 64'(if16.busy), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("short_err_one_cycle", 64'(if16.err), 0);
    repeat (20) @(posedge clk);
    #1;
    check("short_err_count", 64'(err_seen16 - e0), 1);
  endtask

  task automatic reset_mid_solve();
    rand_b();
    load_job(0, 16, 5, 32'h0);   // now in SOLVE cycle 1; nothing expected
    repeat (9) @(posedge clk);
    #1;
    check("busy_before_mid_reset", 64'(if16.busy), 1);
    rst = 1'b1;
    #1;
    check("mid_reset_out_valid", 64'(if16.out_valid), 0);
    check("mid_reset_x_out", 64'(if16.x_out), 0);
    check("mid_reset_busy", 64'(if16.busy), 0);
    check("mid_reset_sweeps", 64'(if16.sweeps_out), 0);
    check("mid_reset_err", 64'(if16.err), 0);
    check("mid_reset_state", 64'(st16), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    rand_b();
    run_job(0, 3, 32'h0, 1'b0);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (if16.out_valid) begin
        if (exp_q16.size() == 0) begin
          tests++; fails++;
          $display("FAIL out16_unexpected: got x_out 0x%0h, expected no output", if16.x_out);
        end else begin
          e16 = exp_q16.pop_front();
          check("out16", 64'({if16.sweeps_out, if16.x_out}), 64'(e16));
        end
      end else begin
        check("idle16_zero", 64'({if16.sweeps_out, if16.x_out}), 0);
      end
      if (if16.err) err_seen16++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (if8.out_valid) begin
        if (exp_q8.size() == 0) begin
          tests++; fails++;
          $display("FAIL out8_unexpected: got x_out 0x%0h, expected no output", if8.x_out);
        end else begin
          e8 = exp_q8.pop_front();
          check("out8", 64'({if8.sweeps_out, if8.x_out}), 64'(e8));
        end
      end else begin
        check("idle8_zero", 64'({if8.sweeps_out, if8.x_out}), 0);
      end
      if (if8.err) err_seen8++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int sel, im;
    logic [31:0] tl;
    drive(0, 1'b0, 16'h0, 8'h0, 32'h0);
    drive(1, 1'b0, 16'h0, 8'h0, 32'h0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst16_outputs", 64'({if16.out_valid, if16.busy, if16.err, if16.sweeps_out, if16.x_out}), 0);
    check("rst16_state", 64'(st16), 0);
    check("rst8_outputs", 64'({if8.out_valid, if8.busy, if8.err, if8.sweeps_out, if8.x_out}), 0);
    check("rst8_state", 64'(st8), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // zero vector
    for (int k = 0; k < 64; k++) bvec[k] = 16'sd0;
    run_job(0, 50, 32'h0, 1'b0);

    // positive then negative unit impulse (back to back)
    bvec[0] = 16'sd20;
    run_job(0, 1, 32'h0, 1'b1);
    bvec[0] = -16'sd20;
    run_job(0, 1, 32'h0, 1'b1);

    // sweep limit versus tolerance exit, N=8
    rand_b();
    run_job(1, 3, 32'h0, 1'b0);
    run_job(1, 3, 32'h7FFFFFFF, 1'b0);
    // iter_max=0 behaves as 1
    run_job(1, 0, 32'h0, 1'b1);

    // short load, then a full load
    short_load();
    rand_b();
    run_job(0, 4, 32'h0, 1'b1);

    reset_mid_solve();

    // random jobs on both instances
    for (int r = 0; r < 10; r++) begin
      sel = int'($urandom_range(0, 1));
      im  = int'($urandom_range(0, 6));
      tl  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 2000)) : $urandom;
      rand_b();
      if (r % 3 == 0) for (int k = 0; k < 64; k++) bvec[k] = 16'($urandom_range(0, 40)) - 16'sd20;
      run_job(sel, im, tl, 1'b1);
    end

    drive(0, 1'b0, 16'h0, 8'h0, 32'h0);
    drive(1, 1'b0, 16'h0, 8'h0, 32'h0);
    repeat (40) @(posedge clk);
    #1;
    check("exp_q16_drained", 64'(exp_q16.size()), 0);
    check("exp_q8_drained", 64'(exp_q8.size()), 0);
    check("err16_total", 64'(err_seen16), 1);
    check("err8_total", 64'(err_seen8), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
